// File: rtl/undistort_map_loader_if.sv
// Map loader bus: host word stream in, LUT write port out.
// slave = loader side, master = host/LUT side.
interface undistort_map_loader_if #(
  parameter int ADDR_W = 20
);
  logic [31:0]       s_data;
  logic              s_valid;
  logic              s_ready;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport slave  (input  s_data, s_valid,
                  output s_ready, wr_en, wr_bank, wr_addr, wr_data);
  modport master (output s_data, s_valid,
                  input  s_ready, wr_en, wr_bank, wr_addr, wr_data);
endinterface

// File: rtl/undistort_map_loader.sv
// Streams a new undistortion map into the shadow LUT bank, verifies its checksum
// and swaps banks only on a vs rising edge so a frame never tears.
module undistort_map_loader #(
  parameter int MAP_WORDS   = 921600,
  parameter int ADDR_W      = 20,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [31:0]           i_exp_csum,
  input  logic                  i_vs,
  undistort_map_loader_if.slave bus,
  output logic                  o_active_bank,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAP_WORDS - 1);
  localparam logic [TMR_W-1:0]  TMO_LAST  = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_PENDING, S_ERROR} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [31:0]       r_csum, r_exp;
  logic [TMR_W-1:0]  r_tmr;
  logic              r_vs_d;
  logic              r_wr_en, r_wr_bank, r_active, r_done, r_err;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;

  logic w_beat, w_rise, w_start_ok, w_swap;

  assign w_beat     = bus.s_valid && (r_state == S_LOAD);
  assign w_rise     = i_vs && !r_vs_d;
  assign w_start_ok = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_swap     = (r_state == S_PENDING) && !i_abort && w_rise;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state logic; abort takes priority over every other exit
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start_ok) w_next = S_LOAD;
      S_LOAD: begin
        if (i_abort)                                w_next = S_IDLE;
        else if (w_beat && (r_cnt == LAST_ADDR))    w_next = S_CHECK;
        else if (!w_beat && (r_tmr == TMO_LAST))    w_next = S_ERROR;
      end
      S_CHECK: begin
        if (i_abort)              w_next = S_IDLE;
        else if (r_csum == r_exp) w_next = S_PENDING;
        else                      w_next = S_ERROR;
      end
      S_PENDING: begin
        if (i_abort)     w_next = S_IDLE;
        else if (w_rise) w_next = S_IDLE;
      end
      S_ERROR:   w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    bus.s_ready = (r_state == S_LOAD);
    o_busy      = (r_state == S_LOAD) || (r_state == S_CHECK) || (r_state == S_PENDING);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_csum    <= '0;
      r_exp     <= '0;
      r_tmr     <= '0;
      r_vs_d    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_bank <= 1'b1;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_vs_d  <= i_vs;
      r_wr_en <= w_beat;
      r_done  <= 1'b0;
      if (w_start_ok) begin
        r_exp  <= i_exp_csum;
        r_cnt  <= '0;
        r_csum <= '0;
        r_tmr  <= '0;
        r_err  <= 1'b0;
      end
      if (w_beat) begin
        r_wr_addr <= r_cnt;
        r_wr_data <= bus.s_data;
        r_csum    <= r_csum + bus.s_data;
        r_cnt     <= (r_cnt == LAST_ADDR) ? r_cnt : r_cnt + ADDR_W'(1);
        r_tmr     <= '0;
      end else if (r_state == S_LOAD) begin
        r_tmr <= r_tmr + TMR_W'(1);
      end
      if (w_next == S_ERROR) r_err <= 1'b1;
      // shadow bank always follows the complement of the active bank
      if (w_swap) begin
        r_active  <= ~r_active;
        r_wr_bank <= r_active;
        r_done    <= 1'b1;
      end
    end
  end

  assign bus.wr_en   = r_wr_en;
  assign bus.wr_bank = r_wr_bank;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign o_active_bank = r_active;
  assign o_done        = r_done;
  assign o_err         = r_err;
endmodule

// File: tb/tb_undistort_map_loader.sv
// Directed bench for undistort_map_loader with a 4-word map and 16-cycle timeout.
module tb_undistort_map_loader;
  localparam int MAP_WORDS = 4, ADDR_W = 2, TIMEOUT_CYC = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_start = 1'b0, i_abort = 1'b0, i_vs = 1'b0;
  logic [31:0] i_exp_csum = '0;
  logic o_active_bank, o_busy, o_done, o_err;
  int n_checks = 0, n_errors = 0;

  undistort_map_loader_if #(.ADDR_W(ADDR_W)) bus ();

  undistort_map_loader #(.MAP_WORDS(MAP_WORDS), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_exp_csum(i_exp_csum),
    .i_vs(i_vs), .bus(bus), .o_active_bank(o_active_bank), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] e);
    i_start = 1'b1; i_exp_csum = e;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input int idx, input logic bank);
    bus.s_valid = 1'b1; bus.s_data = w;
    tick();
    bus.s_valid = 1'b0;
    chk("wr_en", 32'(bus.wr_en), 1);
    chk("wr_addr", 32'(bus.wr_addr), idx);
    chk("wr_data", bus.wr_data, w);
    chk("wr_bank", 32'(bus.wr_bank), 32'(bank));
  endtask

  task automatic vs_pulse();
    i_vs = 1'b1; tick();
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0;
    tick(); tick();
    // reset values
    chk("rst s_ready", 32'(bus.s_ready), 0);
    chk("rst wr_en", 32'(bus.wr_en), 0);
    chk("rst wr_bank", 32'(bus.wr_bank), 1);
    chk("rst wr_addr", 32'(bus.wr_addr), 0);
    chk("rst wr_data", bus.wr_data, 0);
    chk("rst active", 32'(o_active_bank), 0);
    chk("rst busy", 32'(o_busy), 0);
    chk("rst done", 32'(o_done), 0);
    chk("rst err", 32'(o_err), 0);
    rst_n = 1'b1; tick();

    // 1: good load, swap on vs
    bus.s_valid = 1'b1; start(32'h0000000A);
    chk("t1 idle no beat", 32'(bus.wr_en), 0);
    chk("t1 busy", 32'(o_busy), 1);
    chk("t1 s_ready", 32'(bus.s_ready), 1);
    for (int i = 0; i < 4; i++) send(32'(i + 1), i, 1'b1);
    chk("t1 s_ready drop", 32'(bus.s_ready), 0);
    tick();
    chk("t1 wr_en idle", 32'(bus.wr_en), 0);
    chk("t1 pending busy", 32'(o_busy), 1);
    chk("t1 pending err", 32'(o_err), 0);
    vs_pulse();
    chk("t1 done", 32'(o_done), 1);
    chk("t1 active", 32'(o_active_bank), 1);
    chk("t1 busy off", 32'(o_busy), 0);
    chk("t1 wr_bank", 32'(bus.wr_bank), 0);
    tick();
    chk("t1 done pulse", 32'(o_done), 0);
    i_vs = 1'b0; tick();

    // 2: checksum mismatch
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    start(32'h0000000B);
    for (int i = 0; i < 4; i++) send(32'(i + 1), i, 1'b1);
    tick();
    chk("t2 err", 32'(o_err), 1);
    chk("t2 busy", 32'(o_busy), 0);
    tick();
    vs_pulse();
    chk("t2 no done", 32'(o_done), 0);
    chk("t2 active", 32'(o_active_bank), 0);
    chk("t2 err sticky", 32'(o_err), 1);
    i_vs = 1'b0; tick();

    // 3: timeout, then recovery
    start(32'h0000000A);
    chk("t3 err cleared", 32'(o_err), 0);
    send(32'd1, 0, 1'b1);
    send(32'd2, 1, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    chk("t3 still busy", 32'(o_busy), 1);
    chk("t3 no err yet", 32'(o_err), 0);
    tick();
    chk("t3 timeout err", 32'(o_err), 1);
    chk("t3 timeout busy", 32'(o_busy), 0);
    tick();
    start(32'h0000000A);
    chk("t3 restart err", 32'(o_err), 0);
    for (int i = 0; i < 4; i++) send(32'(i + 1), i, 1'b1);
    tick();
    vs_pulse();
    chk("t3 done", 32'(o_done), 1);
    chk("t3 active", 32'(o_active_bank), 1);
    i_vs = 1'b0; tick();

    // 4: vs rise during LOAD is ignored
    start(32'h0000000A);
    send(32'd1, 0, 1'b0);
    send(32'd2, 1, 1'b0);
    vs_pulse();
    chk("t4 load no done", 32'(o_done), 0);
    chk("t4 load active", 32'(o_active_bank), 1);
    chk("t4 load busy", 32'(o_busy), 1);
    i_vs = 1'b0;
    send(32'd3, 2, 1'b0);
    send(32'd4, 3, 1'b0);
    tick();
    chk("t4 pending active", 32'(o_active_bank), 1);
    vs_pulse();
    chk("t4 done", 32'(o_done), 1);
    chk("t4 active", 32'(o_active_bank), 0);
    i_vs = 1'b0; tick();

    // 5: checksum wraps modulo 2^32
    start(32'h00000000);
    send(32'hFFFFFFFF, 0, 1'b1);
    send(32'd1, 1, 1'b1);
    send(32'd0, 2, 1'b1);
    send(32'd0, 3, 1'b1);
    tick();
    chk("t5 pending", 32'(o_busy), 1);
    chk("t5 err", 32'(o_err), 0);
    vs_pulse();
    chk("t5 done", 32'(o_done), 1);
    chk("t5 active", 32'(o_active_bank), 1);
    i_vs = 1'b0; tick();

    // 6: start while busy ignored, abort in PENDING cancels swap
    start(32'h0000000A);
    for (int i = 0; i < 4; i++) send(32'(i + 1), i, 1'b0);
    tick();
    start(32'h0000000B);
    chk("t6 busy start", 32'(o_busy), 1);
    chk("t6 busy err", 32'(o_err), 0);
    i_abort = 1'b1; tick(); i_abort = 1'b0;
    chk("t6 abort idle", 32'(o_busy), 0);
    chk("t6 abort s_ready", 32'(bus.s_ready), 0);
    vs_pulse();
    chk("t6 no done", 32'(o_done), 0);
    chk("t6 active", 32'(o_active_bank), 1);
    i_vs = 1'b0; tick();

    // reset mid-load returns active bank to 0
    start(32'h0000000A);
    send(32'd1, 0, 1'b0);
    rst_n = 1'b0; tick();
    chk("rst mid active", 32'(o_active_bank), 0);
    chk("rst mid busy", 32'(o_busy), 0);
    chk("rst mid wr_en", 32'(bus.wr_en), 0);
    chk("rst mid wr_bank", 32'(bus.wr_bank), 1);
    rst_n = 1'b1; tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
